// File: rtl/dcache_mem_port.sv
// Memory-side initiator for the L1 data cache: serialises writeback/fill block
// transfers onto the data memory's ren/wen handshake, with a per-access watchdog.
`ifndef DMEM_BLOCK_ADDR_SIZE
`define DMEM_BLOCK_ADDR_SIZE 8
`endif
`ifndef DBLOCK_SIZE_BITS
`define DBLOCK_SIZE_BITS 64
`endif

module dcache_mem_port #(
    parameter int ADDR_W  = `DMEM_BLOCK_ADDR_SIZE,
    parameter int BLOCK_W = `DBLOCK_SIZE_BITS,
    parameter int TIMEOUT = 255
) (
    input  logic               clock,
    input  logic               reset,
    input  logic               req_valid,
    input  logic               req_rd,
    input  logic               req_wb,
    input  logic [ADDR_W-1:0]  req_rd_addr,
    input  logic [ADDR_W-1:0]  req_wb_addr,
    input  logic [BLOCK_W-1:0] req_wdata,
    output logic               busy,
    output logic               wb_done,
    output logic               resp_valid,
    output logic [BLOCK_W-1:0] resp_rdata,
    output logic               err,
    output logic               mem_ren,
    output logic               mem_wen,
    output logic [ADDR_W-1:0]  mem_addr,
    output logic [BLOCK_W-1:0] mem_din,
    input  logic               mem_ready,
    input  logic               mem_done,
    input  logic [BLOCK_W-1:0] mem_dout,
    output logic [1:0]         dbg_state
);

    // Handshake: a request transfers on an edge where the port is idle, req_valid=1
    // and at least one of req_rd/req_wb is set; the requester holds it until then.
    // Memory side: the strobe stays high with stable address/data until the
    // matching acknowledge (mem_done for wen, mem_ready for ren) is sampled.

    typedef enum logic [1:0] {IDLE = 2'd0, WB = 2'd1, RD = 2'd2, GAP = 2'd3} state_t;

    localparam logic [7:0] WD_LAST = 8'(TIMEOUT - 1);

    state_t              state_q, state_d;
    logic [7:0]          wd_q;
    logic                pend_rd_q;
    logic [ADDR_W-1:0]   pend_rd_addr_q, pend_wb_addr_q;
    logic [BLOCK_W-1:0]  pend_wdata_q;
    logic                accept, wb_ack, rd_ack, abort;

    assign dbg_state = state_q;

    always_comb begin
        state_d = state_q;
        accept  = 1'b0;
        wb_ack  = 1'b0;
        rd_ack  = 1'b0;
        abort   = 1'b0;
        case (state_q)
            IDLE: begin
                if (req_valid && (req_rd || req_wb)) begin
                    accept  = 1'b1;
                    state_d = req_wb ? WB : RD;
                end
            end
            WB: begin
                if (mem_done) begin
                    wb_ack  = 1'b1;
                    state_d = GAP;
                end else if (wd_q == WD_LAST) begin
                    abort   = 1'b1;
                    state_d = GAP;
                end
            end
            RD: begin
                if (mem_ready) begin
                    rd_ack  = 1'b1;
                    state_d = GAP;
                end else if (wd_q == WD_LAST) begin
                    abort   = 1'b1;
                    state_d = GAP;
                end
            end
            GAP:     state_d = pend_rd_q ? RD : IDLE;
            default: state_d = IDLE;
        endcase
    end

    // Outputs are registered from the next state so strobes change exactly at state entry.
    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            state_q        <= IDLE;
            wd_q           <= 8'd0;
            pend_rd_q      <= 1'b0;
            pend_rd_addr_q <= '0;
            pend_wb_addr_q <= '0;
            pend_wdata_q   <= '0;
            busy           <= 1'b0;
            wb_done        <= 1'b0;
            resp_valid     <= 1'b0;
            resp_rdata     <= '0;
            err            <= 1'b0;
            mem_ren        <= 1'b0;
            mem_wen        <= 1'b0;
            mem_addr       <= '0;
            mem_din        <= '0;
        end else begin
            state_q <= state_d;
            // Counts cycles already spent in the current access; zero on entry.
            if ((state_d == WB || state_d == RD) && state_d == state_q)
                wd_q <= wd_q + 8'd1;
            else
                wd_q <= 8'd0;

            if (accept) begin
                pend_rd_q      <= req_rd;
                pend_rd_addr_q <= req_rd_addr;
                pend_wb_addr_q <= req_wb_addr;
                pend_wdata_q   <= req_wdata;
            end else if (rd_ack || abort) begin
                pend_rd_q <= 1'b0;
            end

            busy    <= (state_d != IDLE);
            mem_wen <= (state_d == WB);
            mem_ren <= (state_d == RD);
            if (state_d == WB) begin
                mem_addr <= accept ? req_wb_addr : pend_wb_addr_q;
                mem_din  <= accept ? req_wdata : pend_wdata_q;
            end else if (state_d == RD) begin
                mem_addr <= accept ? req_rd_addr : pend_rd_addr_q;
            end

            wb_done    <= wb_ack;
            resp_valid <= rd_ack;
            if (rd_ack)
                resp_rdata <= mem_dout;
            if (abort)
                err <= 1'b1;
        end
    end

endmodule

// File: tb/tb_dcache_mem_port.sv
// Bench for dcache_mem_port: a latency-programmable memory model plus a
// request-level reference model predicting data, pulse timing and strobe lengths.
module tb_dcache_mem_port;

    localparam int AW = 8;
    localparam int BW = 64;
    localparam int TO = 8;

    logic          clock = 1'b0;
    logic          reset = 1'b0;
    logic          req_valid = 1'b0, req_rd = 1'b0, req_wb = 1'b0;
    logic [AW-1:0] req_rd_addr = '0, req_wb_addr = '0;
    logic [BW-1:0] req_wdata = '0;
    logic          busy, wb_done, resp_valid, err, mem_ren, mem_wen;
    logic [BW-1:0] resp_rdata, mem_din, mem_dout;
    logic [AW-1:0] mem_addr;
    logic          mem_ready, mem_done;
    logic [1:0]    dbg_state;

    int total = 0;
    int bad   = 0;

    dcache_mem_port #(.ADDR_W(AW), .BLOCK_W(BW), .TIMEOUT(TO)) dut (
        .clock(clock), .reset(reset),
        .req_valid(req_valid), .req_rd(req_rd), .req_wb(req_wb),
        .req_rd_addr(req_rd_addr), .req_wb_addr(req_wb_addr), .req_wdata(req_wdata),
        .busy(busy), .wb_done(wb_done), .resp_valid(resp_valid), .resp_rdata(resp_rdata),
        .err(err), .mem_ren(mem_ren), .mem_wen(mem_wen), .mem_addr(mem_addr),
        .mem_din(mem_din), .mem_ready(mem_ready), .mem_done(mem_done),
        .mem_dout(mem_dout), .dbg_state(dbg_state)
    );

    // ---------------- clock ----------------
    always #5 clock = ~clock;

    function automatic logic [BW-1:0] init_val(input logic [AW-1:0] a);
        return 64'h0123_4567_89AB_CDEF ^ {8{a}};
    endfunction

    // ---------------- memory model ----------------
    logic [BW-1:0] tb_mem [0:255];
    bit            tb_wr  [0:255];
    int            lat_w = 1, lat_r = 1;
    bit            ack_en = 1'b1, noise_en = 1'b0;
    logic          noise = 1'b0;
    logic [7:0]    scnt = 8'd0;
    logic [BW-1:0] rd_val;

    always @(posedge clock) begin
        scnt <= (mem_ren || mem_wen) ? scnt + 8'd1 : 8'd0;
        if (mem_wen && scnt == 8'd0) begin
            tb_mem[mem_addr] <= mem_din;
            tb_wr[mem_addr]  <= 1'b1;
        end
    end

    always @(negedge clock) noise <= noise_en ? 1'($urandom_range(0, 1)) : 1'b0;

    assign rd_val    = tb_wr[mem_addr] ? tb_mem[mem_addr] : init_val(mem_addr);
    assign mem_ready = (mem_ren && ack_en && int'(scnt) == lat_r - 1) || (noise && !mem_ren);
    assign mem_done  = (mem_wen && int'(scnt) == lat_w - 1) || (noise && !mem_wen);
    assign mem_dout  = (mem_ren && mem_ready) ? rd_val : ~rd_val;

    // ---------------- monitor ----------------
    int cyc = 0;
    always @(posedge clock) cyc <= cyc + 1;

    int ren_total = 0, wen_total = 0, busy_total = 0, ovl_total = 0;
    int wbd_total = 0, rv_total = 0, wbd_cyc = 0, rv_cyc = 0, ren_rise = 0;
    bit ren_prev = 1'b0;

    always @(negedge clock) begin
        if (mem_ren && mem_wen) ovl_total++;
        if (mem_ren) begin
            ren_total++;
            if (!ren_prev) ren_rise = cyc;
        end
        ren_prev = mem_ren;
        if (mem_wen) wen_total++;
        if (busy) busy_total++;
        if (wb_done) begin wbd_total++; wbd_cyc = cyc; end
        if (resp_valid) begin rv_total++; rv_cyc = cyc; end
    end

    // ---------------- scoreboard / reference model ----------------
    logic [BW-1:0] exp_q[$];
    logic [BW-1:0] m [0:255];
    logic [BW-1:0] exp_resp = '0;
    logic          exp_err  = 1'b0;

    task automatic chk(input string tag, input logic [BW-1:0] obs, input logic [BW-1:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    // ---------------- driver ----------------
    task automatic run_req(input bit rd, input bit wb, input logic [AW-1:0] ra,
                           input logic [AW-1:0] wa, input logic [BW-1:0] wd,
                           input int lw, input int lr, input bit ack_ok, input bit poke);
        int t, start, rd_start, rd_len, last_busy;
        int b_ren, b_wen, b_busy, b_ovl, b_wbd, b_rv;
        bit done;
        logic [BW-1:0] exp_data;
        lat_w = lw;
        lat_r = lr;
        ack_en = ack_ok;
        @(posedge clock); #1;
        t = cyc;
        b_ren = ren_total; b_wen = wen_total; b_busy = busy_total;
        b_ovl = ovl_total; b_wbd = wbd_total; b_rv = rv_total;
        req_valid = 1'b1; req_rd = rd; req_wb = wb;
        req_rd_addr = ra; req_wb_addr = wa; req_wdata = wd;
        @(posedge clock); #1;
        req_valid = 1'b0;
        if (poke) begin
            @(posedge clock); #1;
            req_valid = 1'b1; req_rd = 1'b1; req_wb = 1'b1;
            req_rd_addr = ra + 8'd1; req_wb_addr = wa + 8'd1;
            @(posedge clock); #1;
            req_valid = 1'b0;
        end
        done = 1'b0;
        for (int k = 0; k < 300; k++) begin
            if (!busy) begin done = 1'b1; break; end
            @(posedge clock); #1;
        end
        chk("idle_reached", done, 1'b1);
        repeat (2) @(posedge clock);
        #1;

        // Expected behaviour from the request-level rules.
        start     = t + 1;
        rd_start  = wb ? start + lw + 1 : start;
        rd_len    = rd ? (ack_ok ? lr : TO) : 0;
        last_busy = rd ? rd_start + rd_len : start + lw;
        if (wb) m[wa] = wd;
        if (rd && ack_ok) begin
            exp_q.push_back(m[ra]);
            exp_resp = m[ra];
        end
        if (rd && !ack_ok) exp_err = 1'b1;

        chk("busy_cycles", busy_total - b_busy, last_busy - start + 1);
        chk("wen_cycles", wen_total - b_wen, wb ? lw : 0);
        chk("ren_cycles", ren_total - b_ren, rd_len);
        chk("strobe_overlap", ovl_total - b_ovl, 0);
        chk("wb_done_count", wbd_total - b_wbd, wb ? 1 : 0);
        if (wb) chk("wb_done_cycle", wbd_cyc, start + lw);
        if (rd) chk("ren_rise_cycle", ren_rise, rd_start);
        chk("resp_valid_count", rv_total - b_rv, (rd && ack_ok) ? 1 : 0);
        if (rd && ack_ok) begin
            exp_data = exp_q.pop_front();
            chk("resp_valid_cycle", rv_cyc, rd_start + rd_len);
            chk("resp_rdata", resp_rdata, exp_data);
        end else begin
            chk("resp_rdata_hold", resp_rdata, exp_resp);
        end
        chk("err", err, exp_err);
    endtask

    // ---------------- stimulus ----------------
    initial begin
        int b_ren, b_wen, b_busy;
        bit r, w;
        for (int i = 0; i < 256; i++) m[i] = init_val(8'(i));

        #1;
        chk("rst_outputs", {busy, wb_done, resp_valid, err, mem_ren, mem_wen}, '0);
        chk("rst_addr_din", {mem_addr, mem_din}, '0);
        chk("rst_rdata", resp_rdata, '0);
        chk("rst_state", dbg_state, 2'd0);
        repeat (3) @(posedge clock);
        @(negedge clock) reset = 1'b1;

        // Fill-only, latency 4.
        run_req(1, 0, 8'h05, 8'h00, '0, 1, 4, 1, 0);
        // Writeback of A5 pattern to 0x10, then fill it back.
        run_req(0, 1, 8'h00, 8'h10, {8{8'hA5}}, 3, 1, 1, 0);
        run_req(1, 0, 8'h10, 8'h00, '0, 1, 2, 1, 0);
        // Eviction: wb 0x03 then rd 0x07.
        run_req(1, 1, 8'h07, 8'h03, 64'hFEED_FACE_0BAD_F00D, 3, 5, 1, 0);
        // req_valid pulsed while busy must not start another access.
        run_req(1, 0, 8'h20, 8'h00, '0, 1, 5, 1, 1);

        // Idle request with neither rd nor wb set.
        @(posedge clock); #1;
        b_ren = ren_total; b_wen = wen_total; b_busy = busy_total;
        req_valid = 1'b1; req_rd = 1'b0; req_wb = 1'b0;
        repeat (3) @(posedge clock);
        #1;
        req_valid = 1'b0;
        @(posedge clock); #1;
        chk("null_req_strobes", (ren_total - b_ren) + (wen_total - b_wen), 0);
        chk("null_req_busy", busy_total - b_busy, 0);

        // Acknowledge arriving on the watchdog's last cycle still completes.
        run_req(1, 0, 8'h31, 8'h00, '0, 1, TO, 1, 0);

        // Randomized traffic with spurious acks in the wrong states.
        noise_en = 1'b1;
        for (int i = 0; i < 12; i++) begin
            r = 1'($urandom_range(0, 1));
            w = r ? 1'($urandom_range(0, 1)) : 1'b1;
            run_req(r, w, 8'($urandom_range(0, 15)), 8'($urandom_range(0, 15)),
                    {$urandom, $urandom}, $urandom_range(1, 7), $urandom_range(1, 7), 1, 0);
        end
        noise_en = 1'b0;

        // Watchdog abort of a fill, then a normal fill with err staying set.
        run_req(1, 0, 8'h44, 8'h00, '0, 1, 1, 0, 0);
        run_req(1, 0, 8'h45, 8'h00, '0, 1, 3, 1, 0);

        // Reset in the 2nd RD cycle.
        lat_r = 6; ack_en = 1'b1;
        @(posedge clock); #1;
        req_valid = 1'b1; req_rd = 1'b1; req_wb = 1'b0; req_rd_addr = 8'h50;
        @(posedge clock); #1;
        req_valid = 1'b0;
        @(posedge clock); #1;
        chk("pre_reset_ren", mem_ren, 1'b1);
        #2 reset = 1'b0;
        #1;
        chk("async_strobes", {mem_ren, mem_wen}, 2'b00);
        chk("mid_rst_outputs", {busy, wb_done, resp_valid, err}, 4'b0000);
        chk("mid_rst_data", {mem_addr, mem_din, resp_rdata}, '0);
        exp_err  = 1'b0;
        exp_resp = '0;
        repeat (2) @(posedge clock);
        @(negedge clock) reset = 1'b1;
        run_req(1, 1, 8'h51, 8'h52, 64'h1122_3344_5566_7788, 2, 3, 1, 0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

    initial begin
        #500000;
        $display("FAIL global_timeout observed=running expected=finished");
        $fatal(1, "simulation time limit");
    end

endmodule
